// File: rtl/alu_op_sequencer.sv
// Step-driven front end for the board ALU: collects A, B and the function code, then captures the result.
// Optional macro ALU_SEQ_CHAIN_EN: a step in DONE loads result[WIDTH-1:0] into A and resumes at GET_B.
module alu_op_sequencer #(
    parameter int WIDTH   = 4,
    parameter int ALU_LAT = 1
) (
    input  logic               CLOCK_50,
    input  logic               reset,
    input  logic               step_n,
    input  logic [WIDTH-1:0]   data_in,
    input  logic [1:0]         fn_in,
    output logic [WIDTH-1:0]   alu_a,
    output logic [WIDTH-1:0]   alu_b,
    output logic [1:0]         alu_fn,
    input  logic [2*WIDTH-1:0] alu_result,
    output logic [2*WIDTH-1:0] result,
    output logic               result_valid,
    output logic               busy,
    output logic [2:0]         state_dbg,
    output logic [7:0]         op_count
);

    typedef enum logic [2:0] {
        GET_A   = 3'd0,
        GET_B   = 3'd1,
        GET_FN  = 3'd2,
        ISSUE   = 3'd3,
        CAPTURE = 3'd4,
        DONE    = 3'd5
    } state_t;

    localparam logic [3:0] LAT_LOAD = 4'(ALU_LAT - 1);

    state_t             state_q, state_d;
    logic               sync1_q, sync1_d;
    logic               sync2_q, sync2_d;
    logic               prev_q, prev_d;
    logic               step_pulse;
    logic [3:0]         lat_q, lat_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [1:0]         fn_q, fn_d;
    logic [2*WIDTH-1:0] res_q, res_d;
    logic               valid_q, valid_d;
    logic [7:0]         ops_q, ops_d;

    // The button is asynchronous; two flops resynchronise it, the third remembers the last level.
    always_comb begin
        sync1_d = step_n;
        sync2_d = sync1_q;
        prev_d  = sync2_q;
    end

    assign step_pulse = prev_q & ~sync2_q;

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            prev_q  <= 1'b1;
            state_q <= GET_A;
            lat_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            fn_q    <= '0;
            res_q   <= '0;
            valid_q <= 1'b0;
            ops_q   <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            prev_q  <= prev_d;
            state_q <= state_d;
            lat_q   <= lat_d;
            a_q     <= a_d;
            b_q     <= b_d;
            fn_q    <= fn_d;
            res_q   <= res_d;
            valid_q <= valid_d;
            ops_q   <= ops_d;
        end
    end

    always_comb begin
        state_d = state_q;
        lat_d   = lat_q;
        a_d     = a_q;
        b_d     = b_q;
        fn_d    = fn_q;
        res_d   = res_q;
        valid_d = valid_q;
        ops_d   = ops_q;
        case (state_q)
            GET_A: begin
                if (step_pulse) begin
                    a_d     = data_in;
                    valid_d = 1'b0;
                    state_d = GET_B;
                end
            end
            GET_B: begin
                if (step_pulse) begin
                    b_d     = data_in;
                    state_d = GET_FN;
                end
            end
            GET_FN: begin
                if (step_pulse) begin
                    fn_d    = fn_in;
                    lat_d   = LAT_LOAD;
                    state_d = ISSUE;
                end
            end
            // Operands are frozen here; steps arriving now are deliberately lost.
            ISSUE: begin
                if (lat_q == 4'd0) begin
                    state_d = CAPTURE;
                end else begin
                    lat_d = lat_q - 4'd1;
                end
            end
            CAPTURE: begin
                res_d   = alu_result;
                valid_d = 1'b1;
                ops_d   = ops_q + 8'd1;
                state_d = DONE;
            end
            DONE: begin
                if (step_pulse) begin
`ifdef ALU_SEQ_CHAIN_EN
                    a_d     = res_q[WIDTH-1:0];
                    valid_d = 1'b0;
                    state_d = GET_B;
`else
                    state_d = GET_A;
`endif
                end
            end
            default: state_d = GET_A;
        endcase
    end

    assign alu_a        = a_q;
    assign alu_b        = b_q;
    assign alu_fn       = fn_q;
    assign result       = res_q;
    assign result_valid = valid_q;
    assign busy         = (state_q == ISSUE) || (state_q == CAPTURE);
    assign state_dbg    = state_q;
    assign op_count     = ops_q;

endmodule
